// File: rtl/spi_flash_pkg.sv
// Shared constants for the paged SPI flash controller: request op codes,
// flash opcodes (3- and 4-byte address variants) and FSM state encoding.
package spi_flash_pkg;

  // Request op field
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SE    = 2'd2;
  localparam logic [1:0] OP_BE    = 2'd3;

  // Flash opcodes
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_READ3 = 8'h03;
  localparam logic [7:0] CMD_READ4 = 8'h13;
  localparam logic [7:0] CMD_PP3   = 8'h02;
  localparam logic [7:0] CMD_PP4   = 8'h12;
  localparam logic [7:0] CMD_SE3   = 8'hD8;
  localparam logic [7:0] CMD_SE4   = 8'hDC;
  localparam logic [7:0] CMD_BE    = 8'hC7;

  // FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WREN  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_PROG  = 3'd3;
  localparam logic [2:0] ST_ERASE = 3'd4;
  localparam logic [2:0] ST_POLL  = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;
  localparam logic [2:0] ST_ACK   = 3'd7;

  // Pick the 4-byte opcode variant when the address is 32 bits wide.
  function automatic logic [7:0] opc_sel(input logic four, input logic [7:0] o3,
                                         input logic [7:0] o4);
    return four ? o4 : o3;
  endfunction

endpackage

// File: rtl/spi_flash_chunk_calc.sv
// Page-program chunk size: min(remain, PAGE_SIZE - page offset).
// Ports:
//   pg_off  in  offset of the current address within its page
//   remain  in  bytes still to program
//   chunk   out bytes to program in this page
module spi_flash_chunk_calc #(
  parameter  int SIZE_W    = 12,
  parameter  int PAGE_SIZE = 256,
  localparam int PG_W      = $clog2(PAGE_SIZE)
) (
  input  logic [PG_W-1:0]   pg_off,
  input  logic [SIZE_W-1:0] remain,
  output logic [SIZE_W-1:0] chunk
);

  // Common width wide enough for both a full page count and the length field.
  localparam int W = (SIZE_W > PG_W + 1) ? SIZE_W : PG_W + 1;

  logic [W-1:0] room, rem_w;

  assign room  = W'(PAGE_SIZE) - W'(pg_off);
  assign rem_w = W'(remain);
  // Result never exceeds remain, so it always fits SIZE_W.
  assign chunk = SIZE_W'((rem_w < room) ? rem_w : room);

endmodule

// File: rtl/spi_flash_ctrl_pg.sv
// Paged SPI flash controller. Turns read / write / sector-erase / bulk-erase
// requests into WREN, READ, PP, SE/BE and RDSR commands for the SPI command
// layer. Writes are split at page boundaries, each chunk followed by a WIP
// poll; polling gives up after POLL_TIMEOUT cycles and reports err.
// Ports:
//   sys_clk, rst                   clock, async active-high reset
//   req/op/req_addr/req_size       request side, sampled in IDLE
//   ack/err                        completion pulse, err = poll timeout
//   wr_data/wr_data_req            write byte stream (pass-through)
//   rd_data/rd_valid               registered read byte stream
//   cmd/cmd_valid/cmd_ack/addr/size command layer handshake
//   data_in/data_req/data_out/data_valid command layer byte path
module spi_flash_ctrl_pg
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W       = 24,
  parameter int          SIZE_W       = 12,
  parameter int          PAGE_SIZE    = 256,
  parameter logic [23:0] POLL_TIMEOUT = 24'd12_000_000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SIZE_W-1:0] req_size,
  output logic              ack,
  output logic              err,
  input  logic [7:0]        wr_data,
  output logic              wr_data_req,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [7:0]        cmd,
  output logic              cmd_valid,
  input  logic              cmd_ack,
  output logic [ADDR_W-1:0] addr,
  output logic [SIZE_W-1:0] size,
  output logic [7:0]        data_in,
  input  logic              data_req,
  input  logic [7:0]        data_out,
  input  logic              data_valid
);

  localparam int   PG_W = $clog2(PAGE_SIZE);
  localparam logic FOUR = (ADDR_W == 32);

  logic [2:0]        state, state_nxt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [SIZE_W-1:0] remain, chunk;
  logic [23:0]       tmo;
  logic              wip, to_flag;
  logic              cmd_done, tmo_hit, wip_now, polling;
  logic              is_cmd;
  logic [7:0]        cmd_nxt;
  logic [SIZE_W-1:0] size_nxt;

  assign data_in     = wr_data;
  assign wr_data_req = data_req;

  spi_flash_chunk_calc #(.SIZE_W(SIZE_W), .PAGE_SIZE(PAGE_SIZE)) u_chunk (
    .pg_off (cur_addr[PG_W-1:0]),
    .remain (remain),
    .chunk  (chunk)
  );

  // Only an ack for a command we actually issued counts.
  assign cmd_done = cmd_valid & cmd_ack;
  assign polling  = (state == ST_POLL) || (state == ST_GAP);
  assign tmo_hit  = polling && (tmo == POLL_TIMEOUT - 24'd1);
  // Status byte may land in the same cycle as cmd_ack.
  assign wip_now  = data_valid ? data_out[0] : wip;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (req && !ack) begin
          if ((op == OP_READ || op == OP_WRITE) && req_size == '0) state_nxt = ST_ACK;
          else if (op == OP_READ)                                  state_nxt = ST_READ;
          else                                                     state_nxt = ST_WREN;
        end
      ST_WREN:  if (cmd_done) state_nxt = (op_q == OP_WRITE) ? ST_PROG : ST_ERASE;
      ST_READ:  if (cmd_done) state_nxt = ST_ACK;
      ST_PROG:  if (cmd_done) state_nxt = ST_POLL;
      ST_ERASE: if (cmd_done) state_nxt = ST_POLL;
      ST_POLL:
        if (tmo_hit)       state_nxt = ST_ACK;
        else if (cmd_done) state_nxt = wip_now ? ST_GAP : ((remain != '0) ? ST_WREN : ST_ACK);
      ST_GAP:   state_nxt = tmo_hit ? ST_ACK : ST_POLL;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command presented by each command state.
  always_comb begin
    is_cmd   = 1'b1;
    cmd_nxt  = CMD_WREN;
    size_nxt = '0;
    case (state)
      ST_WREN:  ;
      ST_READ:  begin cmd_nxt = opc_sel(FOUR, CMD_READ3, CMD_READ4); size_nxt = remain; end
      ST_PROG:  begin cmd_nxt = opc_sel(FOUR, CMD_PP3, CMD_PP4);     size_nxt = chunk;  end
      ST_ERASE: cmd_nxt = (op_q == OP_BE) ? CMD_BE : opc_sel(FOUR, CMD_SE3, CMD_SE4);
      ST_POLL:  begin cmd_nxt = CMD_RDSR; size_nxt = SIZE_W'(1); end
      default:  is_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_READ;
      cur_addr  <= '0;
      remain    <= '0;
      tmo       <= '0;
      wip       <= 1'b0;
      to_flag   <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      cmd       <= CMD_READ3;
      cmd_valid <= 1'b0;
      addr      <= '0;
      size      <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= 1'b0;

      case (state)
        ST_IDLE:
          if (state_nxt != ST_IDLE) begin
            op_q     <= op;
            cur_addr <= req_addr;
            remain   <= req_size;
            err      <= 1'b0;
            to_flag  <= 1'b0;
          end
        ST_PROG:
          if (cmd_done) begin
            cur_addr <= cur_addr + ADDR_W'(chunk);
            remain   <= remain - chunk;
          end
        ST_ACK: begin
          ack <= 1'b1;
          err <= to_flag;
        end
        default: ;
      endcase

      // Timeout window spans all POLL/GAP rounds after one PROG/ERASE.
      if (state_nxt == ST_POLL && (state == ST_PROG || state == ST_ERASE)) tmo <= '0;
      else if (polling)                                                    tmo <= tmo + 24'd1;
      if (tmo_hit) to_flag <= 1'b1;

      if (state == ST_POLL && data_valid) wip <= data_out[0];

      // Any state change drops cmd_valid, so consecutive commands always
      // have at least one idle cycle; a new command loads once state settles.
      if (state_nxt != state) cmd_valid <= 1'b0;
      else if (is_cmd && !cmd_valid) begin
        cmd_valid <= 1'b1;
        cmd       <= cmd_nxt;
        addr      <= cur_addr;
        size      <= size_nxt;
      end

      rd_valid <= (state == ST_READ) && data_valid;
      if (state == ST_READ && data_valid) rd_data <= data_out;
    end
  end

endmodule
